// File: rtl/bf16_vec_loader_44.sv
// BF16 dot-product front end: collects FP32 operand pairs, rounds them to
// BF16 (round-to-nearest-even), packs them into parallel vectors, starts the
// MAC, waits for it with a watchdog, and returns its BF16 result.
module bf16_vec_loader_44 #(
  parameter int NUM_ELEMENTS   = 12,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                        clk_44,
  input  logic                        rst_n_44,
  input  logic                        s_valid_44,
  output logic                        s_ready_44,
  input  logic [31:0]                 s_a_44,
  input  logic [31:0]                 s_b_44,
  output logic [16*NUM_ELEMENTS-1:0]  vec_a_44,
  output logic [16*NUM_ELEMENTS-1:0]  vec_b_44,
  output logic                        start_computation_44,
  input  logic                        computation_done_44,
  input  logic [15:0]                 result_44,
  output logic                        r_valid_44,
  input  logic                        r_ready_44,
  output logic [15:0]                 r_data_44,
  output logic                        err_timeout_44,
  output logic                        busy_44
);

  localparam int CNT_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [WD_W-1:0]   wd;
  logic              accept;
  logic              last_elem;
  logic              wd_expired;

  // FP32 -> BF16 with RNE; NaNs become a quiet NaN, denormals flush to signed zero.
  function automatic logic [15:0] fp32_to_bf16(input logic [31:0] f);
    logic [15:0] r;
    logic        rnd;
    rnd = f[15] & ((|f[14:0]) | f[16]);
    if (f[30:23] == 8'hFF)
      r = (|f[22:0]) ? {f[31], 8'hFF, 7'h40} : f[31:16];
    else if (f[30:23] == 8'h00)
      r = {f[31], 15'h0000};
    else
      r = f[31:16] + {15'h0000, rnd};
    return r;
  endfunction

  assign accept     = s_valid_44 & s_ready_44 & (state == S_LOAD);
  assign last_elem  = (count == CNT_W'(NUM_ELEMENTS - 1));
  assign wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) state <= S_LOAD;
    else           state <= state_nxt;
  end

  // Next-state decode plus the decoded start pulse and busy flag.
  always_comb begin
    state_nxt            = state;
    start_computation_44 = 1'b0;
    busy_44              = (state != S_LOAD);
    case (state)
      S_LOAD:  if (accept && last_elem) state_nxt = S_START;
      S_START: begin
        start_computation_44 = 1'b1;
        state_nxt            = S_WAIT;
      end
      S_WAIT:  if (computation_done_44 || wd_expired) state_nxt = S_RESP;
      S_RESP:  if (r_ready_44) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Registered ready: low in reset, rises the cycle the FSM (re)enters LOAD.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) s_ready_44 <= 1'b0;
    else           s_ready_44 <= (state_nxt == S_LOAD);
  end

  // Slot counter and operand packing; slot index follows acceptance order.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) begin
      count    <= '0;
      vec_a_44 <= '0;
      vec_b_44 <= '0;
    end else if (accept) begin
      count <= last_elem ? '0 : count + CNT_W'(1);
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        if (count == CNT_W'(i)) begin
          vec_a_44[16*i +: 16] <= fp32_to_bf16(s_a_44);
          vec_b_44[16*i +: 16] <= fp32_to_bf16(s_b_44);
        end
      end
    end
  end

  // Watchdog: cleared on START, counts WAIT cycles until done or expiry.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44)
      wd <= '0;
    else if (state == S_START)
      wd <= '0;
    else if (state == S_WAIT && !computation_done_44 && !wd_expired)
      wd <= wd + WD_W'(1);
  end

  // Result capture (MAC value or qNaN on timeout), sticky error, response handshake.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) begin
      r_valid_44     <= 1'b0;
      r_data_44      <= '0;
      err_timeout_44 <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (computation_done_44) begin
            r_data_44  <= result_44;
            r_valid_44 <= 1'b1;
          end else if (wd_expired) begin
            r_data_44      <= 16'h7FC0;
            r_valid_44     <= 1'b1;
            err_timeout_44 <= 1'b1;
          end
        end
        S_RESP:  if (r_ready_44) r_valid_44 <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_vec_loader_44.sv
// Directed bench for bf16_vec_loader_44 with a small MAC model
// (fixed latency, optional forced done level).
module tb_bf16_vec_loader_44;

  localparam int NE = 12;
  localparam int TO = 20;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid;
  logic               s_ready;
  logic [31:0]        s_a, s_b;
  logic [16*NE-1:0]   vec_a, vec_b;
  logic               start;
  logic               done;
  logic [15:0]        result;
  logic               r_valid;
  logic               r_ready;
  logic [15:0]        r_data;
  logic               err;
  logic               busy;

  int n_pass = 0;
  int n_total = 0;

  // MAC model
  logic        mac_en;
  logic        mac_force;
  int          mac_lat;
  int          mac_cnt = 0;
  logic [15:0] mac_res;

  int start_cnt = 0;
  int hs_cnt = 0;

  localparam logic [31:0] CONV_A [NE] = '{
    32'h3F808000, 32'h3F818000, 32'h3F807FFF, 32'h7F7FFFFF, 32'h7FC00001, 32'h80000001,
    32'hFF800000, 32'h7F800000, 32'h3FFFFFFF, 32'hFFC00000, 32'h7F800001, 32'h00000000};
  localparam logic [15:0] EXP_A [NE] = '{
    16'h3F80, 16'h3F82, 16'h3F80, 16'h7F80, 16'h7FC0, 16'h8000,
    16'hFF80, 16'h7F80, 16'h4000, 16'hFFC0, 16'h7FC0, 16'h0000};
  localparam logic [31:0] CONV_B [NE] = '{
    32'hC0490FDB, 32'h007FFFFF, 32'h3F80C000, 32'h3F7F8000, 32'hBF818000, 32'h477FFFFF,
    32'h3F800001, 32'h80000000, 32'hC2F6E979, 32'h3F817FFF, 32'hFF7FFFFF, 32'h40490000};
  localparam logic [15:0] EXP_B [NE] = '{
    16'hC049, 16'h0000, 16'h3F81, 16'h3F80, 16'hBF82, 16'h4780,
    16'h3F80, 16'h8000, 16'hC2F7, 16'h3F81, 16'hFF80, 16'h4049};

  bf16_vec_loader_44 #(.NUM_ELEMENTS(NE), .TIMEOUT_CYCLES(TO)) dut (
    .clk_44(clk), .rst_n_44(rst_n),
    .s_valid_44(s_valid), .s_ready_44(s_ready), .s_a_44(s_a), .s_b_44(s_b),
    .vec_a_44(vec_a), .vec_b_44(vec_b),
    .start_computation_44(start), .computation_done_44(done), .result_44(result),
    .r_valid_44(r_valid), .r_ready_44(r_ready), .r_data_44(r_data),
    .err_timeout_44(err), .busy_44(busy));

  always #5 clk = ~clk;

  // MAC model: done pulses mac_lat-1 WAIT cycles after the start pulse.
  always @(posedge clk) begin
    if (start && mac_en) mac_cnt <= mac_lat;
    else if (mac_cnt > 0) mac_cnt <= mac_cnt - 1;
  end
  assign done   = mac_force | (mac_cnt == 1);
  assign result = mac_res;

  // Count start pulses and result handshakes.
  always @(posedge clk) begin
    if (start) start_cnt++;
    if (r_valid && r_ready) hs_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    bit got;
    int k;
    got = 0;
    k = 0;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    while (!got) begin
      if (k == 200) begin
        $display("FAIL send_pair: s_ready never seen in 200 cycles");
        $fatal(1, "stalled");
      end
      got = s_ready;
      tick();
      k++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_rvalid(output int n);
    n = 0;
    while (!r_valid) begin
      if (n == 500) begin
        $display("FAIL wait_rvalid: r_valid never seen in 500 cycles");
        $fatal(1, "stalled");
      end
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %h want 0", s_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %h want 0", busy); else n_pass++;
    n_total++; if (r_valid !== 1'b0) $display("FAIL rst_r_valid got %h want 0", r_valid); else n_pass++;
    n_total++; if (r_data !== 16'h0) $display("FAIL rst_r_data got %h want 0000", r_data); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err got %h want 0", err); else n_pass++;
    n_total++; if (start !== 1'b0) $display("FAIL rst_start got %h want 0", start); else n_pass++;
    n_total++; if (vec_a !== '0 || vec_b !== '0) $display("FAIL rst_vec got %h / %h want 0", vec_a, vec_b); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready got %h want 1", s_ready); else n_pass++;
  endtask

  task automatic test_basic();
    int base, n;
    base = start_cnt;
    mac_en = 1'b1; mac_lat = 5; mac_res = 16'h4140;
    for (int i = 0; i < NE; i++) send_pair(32'h3F800000, 32'h3F800000);
    n_total++; if (start !== 1'b1) $display("FAIL basic_start got %h want 1", start); else n_pass++;
    n_total++; if (s_ready !== 1'b0 || busy !== 1'b1) $display("FAIL basic_start_ctl got rdy %h busy %h want 0/1", s_ready, busy); else n_pass++;
    n_total++; if (vec_a !== {NE{16'h3F80}}) $display("FAIL basic_vec_a got %h want all 3f80", vec_a); else n_pass++;
    n_total++; if (vec_b !== {NE{16'h3F80}}) $display("FAIL basic_vec_b got %h want all 3f80", vec_b); else n_pass++;
    tick();
    n_total++; if (start !== 1'b0) $display("FAIL basic_start_once got %h want 0", start); else n_pass++;
    wait_rvalid(n);
    n_total++; if (r_data !== 16'h4140) $display("FAIL basic_r_data got %h want 4140", r_data); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if ({r_valid, r_data} !== {1'b1, 16'h4140}) $display("FAIL basic_hold got %h/%h want 1/4140", r_valid, r_data); else n_pass++;
    end
    handshake();
    n_total++; if (r_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) $display("FAIL basic_release got v%h b%h r%h want 0/0/1", r_valid, busy, s_ready); else n_pass++;
    n_total++; if (start_cnt - base !== 1) $display("FAIL basic_start_count got %0d want 1", start_cnt - base); else n_pass++;
  endtask

  task automatic test_conversion();
    int n;
    mac_en = 1'b1; mac_lat = 4; mac_res = 16'h3F00;
    for (int i = 0; i < NE; i++) send_pair(CONV_A[i], CONV_B[i]);
    for (int i = 0; i < NE; i++) begin
      n_total++; if (vec_a[16*i +: 16] !== EXP_A[i]) $display("FAIL conv_a slot %0d got %h want %h", i, vec_a[16*i +: 16], EXP_A[i]); else n_pass++;
      n_total++; if (vec_b[16*i +: 16] !== EXP_B[i]) $display("FAIL conv_b slot %0d got %h want %h", i, vec_b[16*i +: 16], EXP_B[i]); else n_pass++;
    end
    wait_rvalid(n);
    n_total++; if (r_data !== 16'h3F00) $display("FAIL conv_r_data got %h want 3f00", r_data); else n_pass++;
    handshake();
  endtask

  task automatic test_stall();
    logic [16*NE-1:0] ea, eb;
    int n;
    mac_en = 1'b1; mac_lat = 3; mac_res = 16'h1234;
    for (int i = 0; i < NE; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_pair(32'h3F800000 + (i << 16), 32'h40008000 + (i << 16));
      ea[16*i +: 16] = 16'h3F80 + 16'(i);
      eb[16*i +: 16] = 16'h4000 + 16'(i) + 16'(i & 1);
    end
    s_valid = 1'b1; s_a = 32'hFFFFFFFF; s_b = 32'hFFFFFFFF;
    n_total++; if (vec_a !== ea) $display("FAIL stall_vec_a got %h want %h", vec_a, ea); else n_pass++;
    n_total++; if (vec_b !== eb) $display("FAIL stall_vec_b got %h want %h", vec_b, eb); else n_pass++;
    wait_rvalid(n);
    for (int i = 0; i < 7; i++) begin
      n_total++; if ({r_valid, r_data} !== {1'b1, 16'h1234}) $display("FAIL stall_hold cyc %0d got %h/%h want 1/1234", i, r_valid, r_data); else n_pass++;
      n_total++; if (s_ready !== 1'b0) $display("FAIL stall_s_ready cyc %0d got %h want 0", i, s_ready); else n_pass++;
      tick();
    end
    handshake();
    s_valid = 1'b0;
    tick();
    n_total++; if (vec_a !== ea || vec_b !== eb) $display("FAIL stall_no_extra got %h want %h", vec_a, ea); else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    mac_en = 1'b0;
    for (int i = 0; i < NE; i++) send_pair(32'h40400000, 32'h40400000);
    n_total++; if (start !== 1'b1) $display("FAIL to_start got %h want 1", start); else n_pass++;
    n = 0;
    while (!r_valid && n < 100) begin
      tick();
      n++;
    end
    n_total++; if (n !== TO + 1) $display("FAIL to_latency got %0d want %0d", n, TO + 1); else n_pass++;
    n_total++; if (r_data !== 16'h7FC0) $display("FAIL to_r_data got %h want 7fc0", r_data); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL to_err got %h want 1", err); else n_pass++;
    handshake();
    n_total++; if (err !== 1'b1 || r_valid !== 1'b0) $display("FAIL to_after got err %h v %h want 1/0", err, r_valid); else n_pass++;
    mac_en = 1'b1; mac_lat = 5; mac_res = 16'h3C00;
    for (int i = 0; i < NE; i++) send_pair(32'h3F800000, 32'h3F800000);
    wait_rvalid(n);
    n_total++; if (r_data !== 16'h3C00) $display("FAIL to_next_r_data got %h want 3c00", r_data); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL to_sticky got %h want 1", err); else n_pass++;
    handshake();
  endtask

  task automatic test_reset_midload();
    int base, n;
    for (int i = 0; i < 6; i++) send_pair(32'h3F800000, 32'h40000000);
    n_total++; if (vec_a[15:0] !== 16'h3F80) $display("FAIL mid_partial got %h want 3f80", vec_a[15:0]); else n_pass++;
    rst_n = 1'b0;
    #2;
    n_total++; if (vec_a !== '0 || vec_b !== '0) $display("FAIL mid_rst_vec got %h want 0", vec_a); else n_pass++;
    n_total++; if (err !== 1'b0 || r_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) $display("FAIL mid_rst_ctl got e%h v%h b%h r%h want 0", err, r_valid, busy, s_ready); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (s_ready !== 1'b1) $display("FAIL mid_release got %h want 1", s_ready); else n_pass++;
    mac_force = 1'b1;
    repeat (3) tick();
    mac_force = 1'b0;
    n_total++; if (r_valid !== 1'b0 || busy !== 1'b0 || r_data !== 16'h0) $display("FAIL mid_stale_done got v%h b%h d%h want 0", r_valid, busy, r_data); else n_pass++;
    base = start_cnt;
    mac_en = 1'b1; mac_lat = 5; mac_res = 16'h4200;
    for (int i = 0; i < NE; i++) send_pair(32'hC0000000, 32'hC0000000);
    n_total++; if (vec_a !== {NE{16'hC000}} || vec_b !== {NE{16'hC000}}) $display("FAIL mid_reload got %h want all c000", vec_a); else n_pass++;
    wait_rvalid(n);
    n_total++; if (r_data !== 16'h4200) $display("FAIL mid_r_data got %h want 4200", r_data); else n_pass++;
    handshake();
    n_total++; if (start_cnt - base !== 1) $display("FAIL mid_start_count got %0d want 1", start_cnt - base); else n_pass++;
  endtask

  task automatic test_done_held();
    int base, n;
    logic [15:0] want;
    base = hs_cnt;
    mac_en = 1'b0;
    mac_force = 1'b1;
    for (int t = 0; t < 2; t++) begin
      want = (t == 0) ? 16'h5555 : 16'hAAAA;
      mac_res = want;
      for (int i = 0; i < NE; i++) send_pair(32'h3F800000, 32'h3F800000);
      n_total++; if (r_valid !== 1'b0) $display("FAIL held_no_early got %h want 0", r_valid); else n_pass++;
      wait_rvalid(n);
      n_total++; if (n !== 2) $display("FAIL held_latency got %0d want 2", n); else n_pass++;
      n_total++; if (r_data !== want) $display("FAIL held_r_data got %h want %h", r_data, want); else n_pass++;
      mac_res = 16'h0BAD;
      tick();
      n_total++; if (r_data !== want) $display("FAIL held_capture_once got %h want %h", r_data, want); else n_pass++;
      handshake();
      for (int i = 0; i < 3; i++) begin
        n_total++; if (r_valid !== 1'b0 || busy !== 1'b0) $display("FAIL held_load_quiet got v%h b%h want 0/0", r_valid, busy); else n_pass++;
        tick();
      end
    end
    mac_force = 1'b0;
    n_total++; if (hs_cnt - base !== 2) $display("FAIL held_handshakes got %0d want 2", hs_cnt - base); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; r_ready = 1'b0;
    mac_en = 1'b1; mac_force = 1'b0; mac_lat = 5; mac_res = 16'h0;
    test_reset();
    test_basic();
    test_conversion();
    test_stall();
    test_timeout();
    test_reset_midload();
    test_done_held();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bf16_vec_loader_44.md
Name: bf16_vec_loader_44

Overview:
Initiator/front-end for the BF16 dot-product MAC.
- Accepts a stream of 12 FP32 operand pairs over valid/ready.
- Converts each operand to BF16 using round-to-nearest-even (RNE) and packs the results into parallel vectors.
- Pulses start_computation_44, waits for computation_done_44, then returns the BF16 result over a second valid/ready port.
- Watchdog flags a MAC that never completes.

Parameters:
NUM_ELEMENTS, 12, operand pairs per dot product.
TIMEOUT_CYCLES, 1000, maximum WAIT cycles before abort.

Ports:
clk_44  in  1  clock, rising edge.
rst_n_44  in  1  asynchronous active-low reset.
s_valid_44  in  1  input pair valid.
s_ready_44  out  1  loader can accept a pair.
s_a_44  in  32  FP32 element of A.
s_b_44  in  32  FP32 element of B.
vec_a_44  out  16*NUM_ELEMENTS  packed BF16 A; element i at [16i+15:16i].
vec_b_44  out  16*NUM_ELEMENTS  packed BF16 B, same layout.
start_computation_44  out  1  one-cycle start pulse to the MAC.
computation_done_44  in  1  MAC done (level).
result_44  in  16  MAC BF16 result.
r_valid_44  out  1  result valid.
r_ready_44  in  1  result consumer ready.
r_data_44  out  16  returned BF16 result.
err_timeout_44  out  1  sticky timeout flag.
busy_44  out  1  high in any state other than LOAD.

Behaviour:
Reset (asynchronous assert, synchronous-safe release):
- State LOAD, count=0.
- vec_a/vec_b all zero; start_computation_44=0.
- r_valid=0, r_data=0, err_timeout=0, busy=0.
- s_ready=1 one cycle after reset deassertion.

FSM states: LOAD, START, WAIT, RESP.
- LOAD:
  - s_ready=1.
  - Each cycle with s_valid&s_ready: write converted A/B into slot count; count++.
  - The accepting cycle with count==NUM_ELEMENTS-1 moves to START and resets count to 0.
- START:
  - start_computation_44=1 for exactly this cycle; s_ready=0.
  - Next state: WAIT; clear the watchdog.
- WAIT:
  - First cycle with computation_done_44=1: capture result_44 into r_data, set r_valid, go to RESP.
  - Watchdog increments every WAIT cycle. When it reaches TIMEOUT_CYCLES without done: r_data=16'h7FC0 (qNaN), r_valid=1, err_timeout=1 (sticky until reset), go to RESP.
  - computation_done_44 is ignored in every state except WAIT.
- RESP:
  - Hold r_valid and r_data stable until r_ready.
  - Handshake cycle: r_valid falls next cycle; return to LOAD.
  - r_ready already high on entry: exactly one cycle of r_valid.

Vectors change only on LOAD acceptances and stay stable through START/WAIT/RESP.

Throughput:
- Minimum 12 + 1 (START) + MAC latency + 1 (RESP) cycles per dot product.
- No overlap of the next load with WAIT.

FP32→BF16 RNE conversion (per operand f):
- lsb=f[16], g=f[15], st=|f[14:0].
- out = f[31:16] + (g & (st|lsb)).
- Carry into the exponent is legal, including overflow to ±Inf (0x7F80/0xFF80).
- NaN (exp=FF, mant≠0): out = {sign, 8'hFF, 7'h40}.
- ±Inf passes through unchanged.
- Denormal or zero input (exp=0): signed zero {sign, 15'h0}.

Boundaries:
- s_valid while not LOAD: not accepted (s_ready=0); source must hold.
- Reset mid-load or mid-WAIT: partial vectors discarded, returns to the reset state; a MAC done arriving after reset is ignored.
- count never exceeds NUM_ELEMENTS-1.

Test Plan:
1. Load 12 pairs of 0x3F800000 (1.0); MAC model returns 0x4140 after 5 cycles -> vec_a/vec_b every slot 0x3F80; exactly one start pulse the cycle after the 12th accept; r_data=0x4140, r_valid held until r_ready.
2. Conversion vectors into slot 0 -> 0x3F808000 (tie, lsb 0) → 0x3F80; 0x3F818000 (tie, lsb 1) → 0x3F82; 0x3F807FFF → 0x3F80; 0x7F7FFFFF → 0x7F80; 0x7FC00001 → 0x7FC0; 0x80000001 → 0x8000.
3. Random s_valid gaps plus r_ready low for 7 cycles -> no lost or duplicated elements; slot order matches acceptance order; r_data stable while stalled.
4. TIMEOUT_CYCLES=20 with MAC model never asserting done -> r_valid exactly 20 cycles after WAIT entry with r_data=0x7FC0, err_timeout=1; flag remains set through the next normal transaction.
5. Assert rst_n_44 low after 6 accepts, then reload 12 pairs -> after reset: outputs at reset values and count=0; reload completes with a single start pulse; a stale done injected during LOAD has no effect.
6. computation_done_44 held high continuously across two transactions -> each result captured once per WAIT; no spurious r_valid in LOAD.
